// File: rtl/ps2_host_cmd_tx.sv
// ps2_host_cmd_tx: host-to-device PS/2 command transmitter.
// Forces the request-to-send handshake (clock inhibit, then data low), shifts
// start, D0..D7, odd parity and stop on device clock falls, then checks the
// device ACK. The oe outputs are open-drain enables: 1 = pull the line low.
// Optional feature macro: PS2_TX_RETRY_EN (adds MAX_RETRIES automatic retries
// after a missing ACK or a timeout before an error is reported).
module ps2_host_cmd_tx #(
    parameter int CLK_INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES         = 50,
    parameter int TIMEOUT_CYCLES     = 750000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int MAX_RETRIES        = 2
`endif
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_no_ack,
    output logic       error_timeout
);

    localparam int MAX_AB  = (CLK_INHIBIT_CYCLES > RTS_CYCLES) ? CLK_INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_HIT  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bitcnt_q, bitcnt_d;

    logic clk_meta_q, clk_sync_q, clk_sync_dly_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;
    logic fail_no_ack, fail_timeout;

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1) + 1;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         cmd_q, cmd_d;
`endif

    // Frame layout sent LSB first after the start bit: {stop, odd parity, data}.
    function automatic logic [9:0] build_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    // Two-flop synchronizers on the raw lines plus a delayed copy for edge detection.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q     <= 1'b1;
            clk_sync_q     <= 1'b1;
            clk_sync_dly_q <= 1'b1;
            dat_meta_q     <= 1'b1;
            dat_sync_q     <= 1'b1;
        end else begin
            clk_meta_q     <= ps2_clk_in;
            clk_sync_q     <= clk_meta_q;
            clk_sync_dly_q <= clk_sync_q;
            dat_meta_q     <= ps2_dat_in;
            dat_sync_q     <= dat_meta_q;
        end
    end

    assign fall = clk_sync_dly_q & ~clk_sync_q;

    // State, cycle counter, frame shifter and bit counter registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            frame_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            bitcnt_q <= bitcnt_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    // Retry bookkeeping: attempts used so far and the byte to resend.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            retry_q <= '0;
            cmd_q   <= '0;
        end else begin
            retry_q <= retry_d;
            cmd_q   <= cmd_d;
        end
    end
`endif

    // Next-state, line enables and status pulses (pulses fire in the last busy cycle).
    always_comb begin
        state_d          = state_q;
        frame_d          = frame_q;
        bitcnt_d         = bitcnt_q;
        ps2_clk_oe       = 1'b0;
        ps2_dat_oe       = 1'b0;
        busy             = (state_q != ST_IDLE);
        command_was_sent = 1'b0;
        error_no_ack     = 1'b0;
        error_timeout    = 1'b0;
        fail_no_ack      = 1'b0;
        fail_timeout     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d          = retry_q;
        cmd_d            = cmd_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    frame_d  = build_frame(cmd_data);
                    bitcnt_d = '0;
                    state_d  = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = '0;
                    cmd_d    = cmd_data;
`endif
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt_q == INHIBIT_LAST) begin
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                if (cnt_q == RTS_LAST) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ps2_dat_oe = (bitcnt_q == 4'd0) ? 1'b1 : ~frame_q[0];
                if (fall) begin
                    if (bitcnt_q != 4'd0) begin
                        frame_d = {1'b0, frame_q[9:1]};
                    end
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end else if (cnt_q == TIMEOUT_HIT) begin
                    fail_timeout = 1'b1;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    if (dat_sync_q) begin
                        fail_no_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else if (cnt_q == TIMEOUT_HIT) begin
                    fail_timeout = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync_q && dat_sync_q) begin
                    command_was_sent = 1'b1;
                    state_d          = ST_IDLE;
                end else if (cnt_q == TIMEOUT_HIT) begin
                    fail_timeout = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail_no_ack || fail_timeout) begin
            ps2_clk_oe = 1'b0;
            ps2_dat_oe = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                retry_d  = retry_q + 1'b1;
                frame_d  = build_frame(cmd_q);
                bitcnt_d = '0;
                state_d  = ST_INHIBIT;
            end else begin
                error_no_ack  = fail_no_ack;
                error_timeout = fail_timeout;
                state_d       = ST_IDLE;
            end
`else
            error_no_ack  = fail_no_ack;
            error_timeout = fail_timeout;
            state_d       = ST_IDLE;
`endif
        end
    end

    // Counter restarts on every state entry and on device clock falls while the
    // device is clocking; falls during IDLE/INHIBIT/RTS are our own inhibit and ignored.
    always_comb begin
        if (state_d != state_q || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (fall && (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_cmd_tx.sv
// tb_ps2_host_cmd_tx: drives ps2_host_cmd_tx against a PS/2 device model and
// compares every transaction with an expected outcome derived from the protocol rules.
module tb_ps2_host_cmd_tx;

    localparam int INH = 20;
    localparam int RTS = 4;
    localparam int TO  = 200;
`ifdef PS2_TX_RETRY_EN
    localparam int MAXR = 2;
`else
    localparam int MAXR = 0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy;
    logic       command_was_sent, error_no_ack, error_timeout;

    int testsRun    = 0;
    int testsFailed = 0;

    int sentCnt = 0, nakCnt = 0, toCnt = 0, inhPhases = 0, pulseBadCnt = 0;
    int inhRun = 0, rtsRun = 0, lastInh = 0, lastRts = 0;
    logic prevClkOe = 1'b0;

    ps2_host_cmd_tx #(
        .CLK_INHIBIT_CYCLES(INH),
        .RTS_CYCLES(RTS),
        .TIMEOUT_CYCLES(TO)
`ifdef PS2_TX_RETRY_EN
        ,
        .MAX_RETRIES(MAXR)
`endif
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .cmd_data(cmd_data),
        .cmd_valid(cmd_valid),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy(busy),
        .command_was_sent(command_was_sent),
        .error_no_ack(error_no_ack),
        .error_timeout(error_timeout)
    );

    // Open-drain bus: a line is low if either side pulls it.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Passive monitor: counts status pulses, inhibit phases and phase lengths.
    always @(negedge CLOCK_50) begin
        if (command_was_sent) sentCnt <= sentCnt + 1;
        if (error_no_ack)     nakCnt  <= nakCnt + 1;
        if (error_timeout)    toCnt   <= toCnt + 1;
        if ((command_was_sent || error_no_ack || error_timeout) && !busy) pulseBadCnt <= pulseBadCnt + 1;
        if (ps2_clk_oe && !prevClkOe) inhPhases <= inhPhases + 1;
        if (ps2_clk_oe && !ps2_dat_oe) inhRun <= inhRun + 1;
        else if (ps2_clk_oe && ps2_dat_oe) rtsRun <= rtsRun + 1;
        if (!ps2_clk_oe && prevClkOe) begin
            lastInh <= inhRun;
            lastRts <= rtsRun;
            inhRun  <= 0;
            rtsRun  <= 0;
        end
        prevClkOe <= ps2_clk_oe;
    end

    // One command: nakCount = attempts the device refuses, noClock = device silent,
    // extraValid = second request during the transfer, resetAtFall = abort by reset.
    task automatic applyStimulus(input logic [7:0] b, input int nakCount, input bit noClock,
                                 input bit extraValid, input int resetAtFall);
        int expAttempts, expOutcome, attempts, k, n, s0, n0, t0, i0, pb0;
        bit done;
        logic [9:0] expFrame, sampled;
        int parity;

        parity   = ($countones(b) % 2 == 0) ? 1 : 0;
        expFrame = 10'(b) + 10'(parity * 256) + 10'd512;
        if (noClock) begin
            expAttempts = MAXR + 1;
            expOutcome  = 2;
        end else if (nakCount > MAXR) begin
            expAttempts = MAXR + 1;
            expOutcome  = 1;
        end else begin
            expAttempts = nakCount + 1;
            expOutcome  = 0;
        end

        s0 = sentCnt; n0 = nakCnt; t0 = toCnt; i0 = inhPhases; pb0 = pulseBadCnt;
        @(negedge CLOCK_50);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;

        attempts = 0;
        done     = 1'b0;
        while (!done && attempts < MAXR + 3) begin
            k = 0;
            while (!ps2_clk_oe && k < 50) begin @(negedge CLOCK_50); k++; end
            if (!ps2_clk_oe) begin checkOutput("inhibit_start", 0, 1); break; end
            attempts++;
            k = 0;
            while (ps2_clk_oe && k < 100) begin @(negedge CLOCK_50); k++; end
            if (ps2_clk_oe) begin checkOutput("clock_release", 1, 0); break; end

            if (noClock) begin
                n = 0;
                while (!(error_timeout || ps2_clk_oe) && n < 400) begin
                    @(negedge CLOCK_50);
                    n++;
                    cmd_valid = (extraValid && n == 10);
                end
                cmd_valid = 1'b0;
                checkOutput("timeout_cycles", n, (attempts == expAttempts) ? TO : TO + 1);
            end else begin
                repeat (3) @(negedge CLOCK_50);
                checkOutput("start_bit", ps2_dat_in, 0);
                sampled = '0;
                for (int f = 1; f <= 11; f++) begin
                    dev_clk = 1'b0;
                    repeat (4) @(negedge CLOCK_50);
                    if (f == resetAtFall) begin
                        #2 resetn = 1'b0;
                        #1;
                        checkOutput("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
                        checkOutput("reset_status", {busy, command_was_sent, error_no_ack, error_timeout}, 0);
                        dev_clk = 1'b1;
                        dev_dat = 1'b1;
                        repeat (3) @(negedge CLOCK_50);
                        resetn = 1'b1;
                        repeat (5) @(negedge CLOCK_50);
                        return;
                    end
                    if (f <= 10) sampled[f-1] = ps2_dat_in;
                    dev_clk = 1'b1;
                    if (f == 10) dev_dat = (attempts > nakCount) ? 1'b0 : 1'b1;
                    if (f == 11) dev_dat = 1'b1;
                    repeat (4) @(negedge CLOCK_50);
                end
                checkOutput("frame_bits", sampled, expFrame);
            end

            checkOutput("inhibit_len", lastInh, INH);
            checkOutput("rts_len", lastRts, RTS);
            k = 0;
            while (busy && !ps2_clk_oe && k < 100) begin @(negedge CLOCK_50); k++; end
            if (!busy) done = 1'b1;
            else if (!ps2_clk_oe) begin checkOutput("settle", 1, 0); break; end
        end

        repeat (30) @(negedge CLOCK_50);
        checkOutput("attempts", attempts, expAttempts);
        checkOutput("inhibit_phases", inhPhases - i0, expAttempts);
        checkOutput("sent_pulses", sentCnt - s0, (expOutcome == 0) ? 1 : 0);
        checkOutput("no_ack_pulses", nakCnt - n0, (expOutcome == 1) ? 1 : 0);
        checkOutput("timeout_pulses", toCnt - t0, (expOutcome == 2) ? 1 : 0);
        checkOutput("pulse_with_busy", pulseBadCnt - pb0, 0);
        checkOutput("idle_lines", {busy, ps2_clk_oe, ps2_dat_oe}, 0);
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #13;
        checkOutput("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        checkOutput("reset_status", {busy, command_was_sent, error_no_ack, error_timeout}, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        checkOutput("idle_after_reset", {busy, ps2_clk_oe, ps2_dat_oe}, 0);

        applyStimulus(8'hED, 0, 1'b0, 1'b0, 0);
        applyStimulus(8'hF4, 0, 1'b0, 1'b0, 0);
        applyStimulus(8'hA5, 9, 1'b0, 1'b0, 0);
        applyStimulus(8'h3C, 0, 1'b1, 1'b1, 0);
        applyStimulus(8'h96, 0, 1'b0, 1'b0, 5);
        applyStimulus(8'h55, 0, 1'b0, 1'b0, 0);
        applyStimulus(8'hF3, 2, 1'b0, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 4) == 0), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
